// File: rtl/vga_fb_pkg.sv
// Shared frame-buffer definitions: image geometry, bus widths, loader states.
package vga_fb_pkg;

    localparam int IMG_W     = 400;
    localparam int IMG_H     = 300;
    localparam int DATA_W    = 24;
    localparam int ADDR_W    = 17;
    localparam int FB_PIXELS = IMG_W * IMG_H;

    typedef logic [DATA_W-1:0] pixel_t;
    typedef logic [ADDR_W-1:0] addr_t;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_DONE = 2'd2
    } ld_state_t;

    localparam pixel_t BLACK = '0;

endpackage

// File: rtl/vga_fb_arbiter_if.sv
// Frame-buffer arbiter bus: VGA timing in, pixel out, loader handshake, RAM port.
// Slave is the arbiter; master is the surrounding system (timing gen, loader, RAM).
interface vga_fb_arbiter_if import vga_fb_pkg::*; ();

    logic [10:0] vga_xpos;
    logic [10:0] vga_ypos;
    logic        vga_de;
    pixel_t      vga_data;

    logic        ld_start;
    logic        ld_valid;
    pixel_t      ld_data;
    logic        ld_ready;
    logic        ld_busy;
    logic        ld_done;

    addr_t       ram_addr;
    pixel_t      ram_wdata;
    logic        ram_wren;
    pixel_t      ram_rdata;

    modport slave (
        input  vga_xpos, vga_ypos, vga_de, ld_start, ld_valid, ld_data, ram_rdata,
        output vga_data, ld_ready, ld_busy, ld_done, ram_addr, ram_wdata, ram_wren
    );

    modport master (
        output vga_xpos, vga_ypos, vga_de, ld_start, ld_valid, ld_data, ram_rdata,
        input  vga_data, ld_ready, ld_busy, ld_done, ram_addr, ram_wdata, ram_wren
    );

endinterface

// File: rtl/vga_fb_addr_gen.sv
// Maps a 2x-upscaled display position to a frame-buffer address and flags read slots.
// Purely combinational, no backpressure.
module vga_fb_addr_gen #(
    parameter int IMG_W = vga_fb_pkg::IMG_W,
    parameter int IMG_H = vga_fb_pkg::IMG_H
) (
    input  logic [10:0]        i_xpos,
    input  logic [10:0]        i_ypos,
    input  logic               i_de,
    output logic               o_in_range,
    output logic               o_read_slot,
    output vga_fb_pkg::addr_t  o_rd_addr
);
    import vga_fb_pkg::*;

    localparam addr_t IMG_W_V = addr_t'(IMG_W);

    logic [9:0] w_x;
    logic [9:0] w_y;
    addr_t      w_row_base;

    assign w_x = i_xpos[10:1];
    assign w_y = i_ypos[10:1];

    // Row base = y * IMG_W unrolled into one shifted add per set bit of the constant.
    always_comb begin
        w_row_base = '0;
        for (int b = 0; b < ADDR_W; b++) begin
            if (IMG_W_V[b]) begin
                w_row_base = w_row_base + (addr_t'(w_y) << b);
            end
        end
    end

    assign o_in_range  = i_de && (int'(w_x) < IMG_W) && (int'(w_y) < IMG_H);
    assign o_read_slot = o_in_range && !i_xpos[0];
    assign o_rd_addr   = w_row_base + addr_t'(w_x);

endmodule

// File: rtl/vga_fb_arbiter.sv
// Shares the frame-buffer RAM between the real-time VGA fetch (absolute priority) and a raster loader.
// Pixel out RD_LAT+1 cycles after xpos; the loader is stalled via ld_ready in every read slot.
module vga_fb_arbiter #(
    parameter int IMG_W  = vga_fb_pkg::IMG_W,
    parameter int IMG_H  = vga_fb_pkg::IMG_H,
    parameter int RD_LAT = 1
) (
    input  logic              i_clk_25m,
    input  logic              i_rst,
    vga_fb_arbiter_if.slave   bus
);
    import vga_fb_pkg::*;

    localparam addr_t LAST_ADDR = addr_t'(IMG_W * IMG_H - 1);

    ld_state_t          r_state;
    ld_state_t          w_state_nxt;
    addr_t              r_wr_cnt;
    addr_t              w_wr_cnt_nxt;
    logic [RD_LAT-1:0]  r_rd_vld;
    logic [RD_LAT-1:0]  r_hold_vld;
    pixel_t             r_pix;

    logic               w_in_range;
    logic               w_read_slot;
    addr_t              w_rd_addr;
    logic               w_xfer;

    vga_fb_addr_gen #(
        .IMG_W (IMG_W),
        .IMG_H (IMG_H)
    ) u_addr_gen (
        .i_xpos      (bus.vga_xpos),
        .i_ypos      (bus.vga_ypos),
        .i_de        (bus.vga_de),
        .o_in_range  (w_in_range),
        .o_read_slot (w_read_slot),
        .o_rd_addr   (w_rd_addr)
    );

    assign bus.ld_ready  = (r_state == ST_LOAD) && !w_read_slot;
    assign w_xfer        = bus.ld_valid && bus.ld_ready;
    assign bus.ram_addr  = w_read_slot ? w_rd_addr : r_wr_cnt;
    assign bus.ram_wdata = w_xfer ? bus.ld_data : BLACK;
    assign bus.ram_wren  = w_xfer;
    assign bus.ld_busy   = (r_state == ST_LOAD);
    assign bus.ld_done   = (r_state == ST_DONE);
    assign bus.vga_data  = r_pix;

    always_comb begin
        w_state_nxt  = r_state;
        w_wr_cnt_nxt = r_wr_cnt;
        case (r_state)
            ST_IDLE: begin
                if (bus.ld_start) begin
                    w_state_nxt  = ST_LOAD;
                    w_wr_cnt_nxt = '0;
                end
            end
            ST_LOAD: begin
                if (w_xfer) begin
                    if (r_wr_cnt == LAST_ADDR) begin
                        w_state_nxt  = ST_DONE;
                        w_wr_cnt_nxt = '0;
                    end else begin
                        w_wr_cnt_nxt = r_wr_cnt + addr_t'(1);
                    end
                end
            end
            ST_DONE: w_state_nxt = ST_IDLE;
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // Odd columns carry a hold flag so the even-column fetch is shown twice.
    always_ff @(posedge i_clk_25m) begin
        if (i_rst) begin
            r_state    <= ST_IDLE;
            r_wr_cnt   <= '0;
            r_rd_vld   <= '0;
            r_hold_vld <= '0;
            r_pix      <= BLACK;
        end else begin
            r_state       <= w_state_nxt;
            r_wr_cnt      <= w_wr_cnt_nxt;
            r_rd_vld[0]   <= w_read_slot;
            r_hold_vld[0] <= w_in_range && bus.vga_xpos[0];
            for (int i = 1; i < RD_LAT; i++) begin
                r_rd_vld[i]   <= r_rd_vld[i-1];
                r_hold_vld[i] <= r_hold_vld[i-1];
            end
            if (r_rd_vld[RD_LAT-1]) begin
                r_pix <= bus.ram_rdata;
            end else if (!r_hold_vld[RD_LAT-1]) begin
                r_pix <= BLACK;
            end
        end
    end

endmodule

// File: doc/vga_fb_arbiter.md
Name: vga_fb_arbiter

Overview:
- Shares one single-port 24-bit image RAM (400x300, 2x upscaled to 800x600) between two requesters:
  - the VGA pixel fetch, which is real-time and has absolute priority;
  - a streaming image loader, which writes raster-order pixels with a valid/ready handshake.
- Sits between the VGA timing generator (xpos/ypos/de) and the RAM.
- Replaces the fixed ROM path so the displayed picture can be reloaded at run time.

Parameters:
- IMG_W, 400, stored image width in pixels.
- IMG_H, 300, stored image height in lines.
- ADDR_W, 17, RAM address width; must satisfy 2^ADDR_W >= IMG_W*IMG_H.
- DATA_W, 24, pixel width, RGB888.
- RD_LAT, 1, RAM read latency in cycles. Supported values: 1 or 2.

Ports:
- clk_25m, in, 1, pixel clock; all logic is on its rising edge.
- rst, in, 1, synchronous active-high reset.
- vga_xpos, in, 11, current display column, 0..799 while active.
- vga_ypos, in, 11, current display line, 0..599 while active.
- vga_de, in, 1, active-video qualifier for xpos/ypos.
- vga_data, out, DATA_W, pixel to the DAC, registered.
- ld_start, in, 1, single-cycle pulse that begins a full-frame load.
- ld_valid, in, 1, loader pixel valid.
- ld_data, in, DATA_W, loader pixel, raster order.
- ld_ready, out, 1, arbiter accepts ld_data this cycle.
- ld_busy, out, 1, high while a load is in progress.
- ld_done, out, 1, one-cycle pulse after the last pixel is written.
- ram_addr, out, ADDR_W, RAM address.
- ram_wdata, out, DATA_W, RAM write data.
- ram_wren, out, 1, RAM write enable.
- ram_rdata, in, DATA_W, RAM read data, valid RD_LAT cycles after address.

Behaviour:
- Reset: vga_data=0, ld_ready=0, ld_busy=0, ld_done=0, ram_wren=0, ram_addr=0, ram_wdata=0, write counter=0, FSM=IDLE, read pipeline valid bits cleared.
- Reset mid-load aborts the load without an ld_done pulse; RAM contents are left as is.
- Read slot definition: a cycle is a read slot iff vga_de=1, vga_xpos[0]=0, (xpos>>1)<IMG_W and (ypos>>1)<IMG_H.
  - In a read slot, ram_addr = (xpos>>1) + (ypos>>1)*IMG_W.
  - The multiply is a constant shift-add, computed within the cycle; no DSP is used.
  - ram_wren=0 in a read slot.
- Read pipeline:
  - A valid bit is carried for RD_LAT cycles. When it emerges, ram_rdata is captured into the pixel register, and vga_data is driven from that register.
  - Latency from the xpos presentation to vga_data is RD_LAT+1 cycles.
  - Each fetched pixel is held for 2 cycles, covering the even and odd columns of the upscale.
  - A de=0 or out-of-range slot propagates as "black": vga_data=0 at the same latency.
- Write slot: every cycle that is not a read slot.
  - ld_ready = ld_busy AND NOT read_slot. This is combinational from vga_de/vga_xpos and the FSM state.
  - A transfer occurs when ld_valid AND ld_ready. In that cycle: ram_addr=wr_cnt, ram_wdata=ld_data, ram_wren=1.
  - After a transfer, wr_cnt increments.
  - Over the active region the loader gets 50% of cycles; during blanking it gets 100%.
- FSM:
  - IDLE: ld_busy=0. ld_start -> LOAD, with wr_cnt=0.
  - LOAD: ld_busy=1. A transfer with wr_cnt = IMG_W*IMG_H-1 -> DONE, and wr_cnt wraps to 0.
  - DONE: ld_done=1 for one cycle and ld_busy=0; unconditionally -> IDLE.
  - ld_start in LOAD or DONE is ignored.
  - ld_valid outside LOAD is ignored (ld_ready=0).
- No tearing protection: display reads during a load return whatever is stored at that moment.
- Width rules:
  - The xpos/ypos shifts discard bit 0.
  - The address sum is computed at ADDR_W bits; max 119999 < 2^17.
  - wr_cnt is ADDR_W bits wide.

Decomposition:
- Shared package vga_fb_pkg holds:
  - IMG_W, IMG_H, DATA_W, ADDR_W;
  - FB_PIXELS = IMG_W*IMG_H;
  - the FSM state encoding (IDLE, LOAD, DONE);
  - the BLACK pixel constant.
- The display timing constants H_DISP=800 and V_DISP=600 stay in the existing VGA parameter header.
- One sub-module: vga_fb_addr_gen. It performs the combinational xpos/ypos -> address conversion and range check, producing read_slot and rd_addr.
- The FSM, arbitration and read pipeline stay in the top.

Test Plan:
- Reset then idle frame: RAM preloaded with data=address, RD_LAT=1. xpos=6, ypos=4, de=1 -> ram_addr=3+2*400=803 -> vga_data=803 two cycles later, held for xpos=7. ld_ready stays 0 throughout.
- Out-of-range/blanking: de=0 -> vga_data=0 at the same latency. ypos=600 with de=1 (forced) -> no read, vga_data=0.
- Load during blanking: ld_start, then ld_valid held with data=0xA00000+n while de=0 -> ld_ready=1 every cycle, 120000 writes at addresses 0..119999, a single ld_done pulse, then ld_busy=0. Readback shows the pattern.
- Load during active video: ld_valid=1 with de=1 and xpos sweeping -> ld_ready=1 only on odd xpos. Display reads are unaffected: no ram_wren in any even-xpos cycle, and vga_data stays correct.
- Handshake stalls: ld_valid toggled randomly 30% low, plus a ld_start pulse mid-load -> ld_start is ignored, no pixel is lost or duplicated, and the final wr_cnt wraps to 0.
- Reset mid-load: rst=1 for 1 cycle at wr_cnt=5000 -> ld_busy=0 and no ld_done. A new ld_start restarts writing at address 0.
